// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot blocks: gate FSM encodings and
// default lot dimensions used by the occupancy, display and LED logic.
package parking_pkg;

    localparam int DEF_CAPACITY         = 8;
    localparam int DEF_CNT_W            = 4;
    localparam int DEF_GATE_OPEN_CYCLES = 3;

    typedef enum logic {
        G_IDLE = 1'b0,
        G_OPEN = 1'b1
    } gate_state_e;

    typedef enum logic {
        E_IDLE = 1'b0,
        E_OPEN = 1'b1
    } entry_state_e;

    typedef enum logic {
        X_IDLE = 1'b0,
        X_OPEN = 1'b1
    } exit_state_e;

endpackage

// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor and status bundle between the gate sensors, the occupancy controller
// and the indicators. The sensor side is the master, the controller the slave.
interface parking_occupancy_ctrl_if #(
    parameter int CNT_W = parking_pkg::DEF_CNT_W
);
    logic             entry_req;
    logic             exit_req;
    logic             entry_gate_open;
    logic             exit_gate_open;
    logic [CNT_W-1:0] occupancy;
    logic             lot_full;
    logic             lot_empty;
    logic             full_signal;

    modport master (
        output entry_req, exit_req,
        input  entry_gate_open, exit_gate_open, occupancy,
               lot_full, lot_empty, full_signal
    );

    modport slave (
        input  entry_req, exit_req,
        output entry_gate_open, exit_gate_open, occupancy,
               lot_full, lot_empty, full_signal
    );
endinterface

// File: rtl/gate_timer.sv
// One barrier: rising-edge detect on the sensor, idle/open FSM and a dwell
// counter holding the gate open for GATE_OPEN_CYCLES clocks.
module gate_timer
    import parking_pkg::*;
#(
    parameter int GATE_OPEN_CYCLES = DEF_GATE_OPEN_CYCLES
) (
    input  logic clk_1Hz,
    input  logic reset,
    input  logic req,
    input  logic allow,
    output logic accept,
    output logic refuse,
    output logic gate_open
);
    localparam int            TW     = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(GATE_OPEN_CYCLES - 1);

    logic          req_q;
    logic          req_edge;
    gate_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;

    assign req_edge = req & ~req_q;

    always_ff @(posedge clk_1Hz or negedge reset) begin
        if (!reset) begin
            req_q   <= 1'b0;
            state_q <= G_IDLE;
            timer_q <= '0;
        end else begin
            req_q   <= req;
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Edges seen while the gate is open are dropped, not queued.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        accept  = 1'b0;
        refuse  = 1'b0;
        case (state_q)
            G_IDLE: begin
                if (req_edge) begin
                    if (allow) begin
                        accept  = 1'b1;
                        state_d = G_OPEN;
                        timer_d = T_LOAD;
                    end else begin
                        refuse = 1'b1;
                    end
                end
            end
            G_OPEN: begin
                if (timer_q == '0) begin
                    state_d = G_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = G_IDLE;
        endcase
    end

    assign gate_open = (state_q == G_OPEN);

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Lot occupancy counter: entry/exit gates with fixed dwell, full/empty flags
// and a one-cycle full_signal pulse for every entry refused at capacity.
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY         = DEF_CAPACITY,
    parameter int CNT_W            = DEF_CNT_W,
    parameter int GATE_OPEN_CYCLES = DEF_GATE_OPEN_CYCLES
) (
    input  logic                     clk_1Hz,
    input  logic                     reset,
    parking_occupancy_ctrl_if.slave  bus
);
    localparam int               GATES    = 2;
    localparam int               ENTRY    = 0;
    localparam int               EXIT     = 1;
    localparam logic [CNT_W-1:0] CAP_VAL  = CNT_W'(CAPACITY);
    // Only a refused entry drives the full indicator; an exit at empty is silent.
    localparam logic [GATES-1:0] FULL_SRC = GATES'(1) << ENTRY;

    logic [GATES-1:0] req;
    logic [GATES-1:0] allow;
    logic [GATES-1:0] accept;
    logic [GATES-1:0] refuse;
    logic [GATES-1:0] gate_open;

    logic [CNT_W-1:0] occupancy_q, occupancy_d;
    logic             full_signal_q, full_signal_d;

    assign req[ENTRY]   = bus.entry_req;
    assign req[EXIT]    = bus.exit_req;
    assign allow[ENTRY] = (occupancy_q < CAP_VAL);
    assign allow[EXIT]  = (occupancy_q != '0);

    generate
        for (genvar gi = 0; gi < GATES; gi++) begin : g_gate
            gate_timer #(
                .GATE_OPEN_CYCLES(GATE_OPEN_CYCLES)
            ) u_gate_timer (
                .clk_1Hz  (clk_1Hz),
                .reset    (reset),
                .req      (req[gi]),
                .allow    (allow[gi]),
                .accept   (accept[gi]),
                .refuse   (refuse[gi]),
                .gate_open(gate_open[gi])
            );
        end
    endgenerate

    // Both allow terms come from the pre-update count, so bounds hold without a clamp.
    always_comb begin
        occupancy_d = occupancy_q;
        case (accept)
            2'b01:   occupancy_d = occupancy_q + 1'b1;
            2'b10:   occupancy_d = occupancy_q - 1'b1;
            default: occupancy_d = occupancy_q;
        endcase
        full_signal_d = |(refuse & FULL_SRC);
    end

    always_ff @(posedge clk_1Hz or negedge reset) begin
        if (!reset) begin
            occupancy_q   <= '0;
            full_signal_q <= 1'b0;
        end else begin
            occupancy_q   <= occupancy_d;
            full_signal_q <= full_signal_d;
        end
    end

    assign bus.occupancy       = occupancy_q;
    assign bus.lot_full        = (occupancy_q == CAP_VAL);
    assign bus.lot_empty       = (occupancy_q == '0);
    assign bus.entry_gate_open = gate_open[ENTRY];
    assign bus.exit_gate_open  = gate_open[EXIT];
    assign bus.full_signal     = full_signal_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl: stimulus pushes hand-computed
// per-cycle expectations, a monitor pops and compares after each clock edge.
module tb_parking_occupancy_ctrl;

    localparam int CAP = 8;

    logic clk_1Hz = 1'b0;
    logic reset   = 1'b0;

    parking_occupancy_ctrl_if #(.CNT_W(4)) bus ();

    parking_occupancy_ctrl #(
        .CAPACITY        (CAP),
        .CNT_W           (4),
        .GATE_OPEN_CYCLES(3)
    ) dut (
        .clk_1Hz(clk_1Hz),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    typedef struct {
        int    cyc;
        string name;
        int    occ;
        bit    eg;
        bit    xg;
        bit    fs;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   errors   = 0;
    int   checks   = 0;

    task automatic check_now(exp_t e);
        bit lf;
        bit le;
        lf = (e.occ == CAP);
        le = (e.occ == 0);
        checks++;
        if (bus.occupancy !== 4'(e.occ) || bus.entry_gate_open !== e.eg ||
            bus.exit_gate_open !== e.xg || bus.full_signal !== e.fs ||
            bus.lot_full !== lf || bus.lot_empty !== le) begin
            errors++;
            $display("FAIL %s cyc=%0d got occ=%0d eg=%b xg=%b fs=%b full=%b empty=%b, expected occ=%0d eg=%b xg=%b fs=%b full=%b empty=%b",
                     e.name, e.cyc, bus.occupancy, bus.entry_gate_open, bus.exit_gate_open,
                     bus.full_signal, bus.lot_full, bus.lot_empty,
                     e.occ, e.eg, e.xg, e.fs, lf, le);
        end else begin
            $display("ok   %s cyc=%0d occ=%0d eg=%b xg=%b fs=%b", e.name, e.cyc,
                     e.occ, e.eg, e.xg, e.fs);
        end
    endtask

    // Monitor: compare every expectation due at the edge just taken.
    initial begin
        forever begin
            @(posedge clk_1Hz);
            edge_cnt++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc < edge_cnt) begin
                    errors++;
                    checks++;
                    $display("FAIL %s missed expectation cyc=%0d now=%0d", e.name, e.cyc, edge_cnt);
                end else begin
                    check_now(e);
                end
            end
        end
    end

    task automatic expect_k(int k, string name, int occ, bit eg, bit xg, bit fs);
        exp_t e;
        e.cyc  = edge_cnt + k;
        e.name = name;
        e.occ  = occ;
        e.eg   = eg;
        e.xg   = xg;
        e.fs   = fs;
        sb.push_back(e);
    endtask

    task automatic step(bit e, bit x);
        @(negedge clk_1Hz);
        bus.entry_req = e;
        bus.exit_req  = x;
    endtask

    // One-cycle sensor pulse; expectations cover the 3-cycle dwell and the closed cycle.
    task automatic request(bit e, bit x, string name, int occ, bit eg, bit xg, bit fs);
        step(e, x);
        expect_k(1, name, occ, eg, xg, fs);
        expect_k(2, name, occ, eg, xg, 1'b0);
        expect_k(3, name, occ, eg, xg, 1'b0);
        expect_k(4, {name, "_closed"}, occ, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0);
    endtask

    initial begin
        exp_t r;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;

        repeat (2) @(negedge clk_1Hz);
        expect_k(1, "reset", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_1Hz);
        reset = 1'b1;

        request(1'b1, 1'b0, "ent1", 1, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent2", 2, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent3", 3, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent4", 4, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent5", 5, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent6", 6, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent7", 7, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent8", 8, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "refused_full", 8, 1'b0, 1'b0, 1'b1);
        request(1'b1, 1'b1, "both_at_cap", 7, 1'b0, 1'b1, 1'b1);
        request(1'b0, 1'b1, "exit6", 6, 1'b0, 1'b1, 1'b0);
        request(1'b0, 1'b1, "exit5", 5, 1'b0, 1'b1, 1'b0);
        request(1'b0, 1'b1, "exit4", 4, 1'b0, 1'b1, 1'b0);
        request(1'b1, 1'b1, "both_at4", 4, 1'b1, 1'b1, 1'b0);
        request(1'b0, 1'b1, "exit3", 3, 1'b0, 1'b1, 1'b0);
        request(1'b0, 1'b1, "exit2", 2, 1'b0, 1'b1, 1'b0);
        request(1'b0, 1'b1, "exit1", 1, 1'b0, 1'b1, 1'b0);
        request(1'b0, 1'b1, "exit0", 0, 1'b0, 1'b1, 1'b0);
        request(1'b0, 1'b1, "exit_at_empty", 0, 1'b0, 1'b0, 1'b0);

        // Entry sensor held high for 10 cycles is a single request.
        step(1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) expect_k(k, "held_open", 1, 1'b1, 1'b0, 1'b0);
        for (int k = 4; k <= 11; k++) expect_k(k, "held_shut", 1, 1'b0, 1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        request(1'b1, 1'b0, "ent_b2", 2, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent_b3", 3, 1'b1, 1'b0, 1'b0);
        request(1'b1, 1'b0, "ent_b4", 4, 1'b1, 1'b0, 1'b0);

        // Reset asserted mid-cycle while the entry gate is open at occupancy 5.
        step(1'b1, 1'b0);
        expect_k(1, "ent_b5", 5, 1'b1, 1'b0, 1'b0);
        @(posedge clk_1Hz);
        @(posedge clk_1Hz);
        #3;
        bus.entry_req = 1'b0;
        reset         = 1'b0;
        #1;
        r.cyc  = edge_cnt;
        r.name = "async_reset";
        r.occ  = 0;
        r.eg   = 1'b0;
        r.xg   = 1'b0;
        r.fs   = 1'b0;
        check_now(r);
        @(negedge clk_1Hz);
        expect_k(1, "reset_hold", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_1Hz);
        reset = 1'b1;
        expect_k(1, "post_reset", 0, 1'b0, 1'b0, 1'b0);
        request(1'b1, 1'b0, "first_after_reset", 1, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk_1Hz);
        #2;
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
